// File: rtl/cluster_unpacker1536.sv
// Receive-side decoder for the 1536-pad cluster stream: rebuilds per-frame start flags,
// counts and an expanded hit map, double-buffered so the last frame stays stable.
module cluster_unpacker1536 #(
  parameter int MXPADS     = 1536,
  parameter int MXCLUSTERS = 8
) (
  input  logic                  clock,
  input  logic                  global_reset,
  input  logic                  frame_start,
  input  logic [10:0]           adr,
  input  logic [2:0]            cnt,
  output logic [MXPADS-1:0]     vpfs,
  output logic [MXPADS*3-1:0]   cnts,
  output logic [MXPADS-1:0]     hits,
  output logic [3:0]            n_clusters,
  output logic                  bad_adr,
  output logic                  frame_valid,
  output logic                  sync_err
);

  localparam int          AW       = $clog2(MXPADS);
  localparam int          CW       = $clog2(MXPADS * 3);
  localparam int          WW       = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
  localparam logic [11:0] PADS12   = 12'(MXPADS);
  localparam logic [10:0] NULL_ADR = 11'h7FE;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         widx_q, widx_d;
  logic                  ready_q;

  logic [MXPADS-1:0]     work_vpfs_q, work_vpfs_d;
  logic [MXPADS*3-1:0]   work_cnts_q, work_cnts_d;
  logic [MXPADS-1:0]     work_hits_q, work_hits_d;
  logic [3:0]            work_n_q, work_n_d;
  logic                  work_bad_q, work_bad_d;

  logic [MXPADS-1:0]     vpfs_q, vpfs_d;
  logic [MXPADS*3-1:0]   cnts_q, cnts_d;
  logic [MXPADS-1:0]     hits_q, hits_d;
  logic [3:0]            n_q, n_d;
  logic                  bad_q, bad_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  sync_err_q, sync_err_d;

  logic                  word_valid;
  logic                  word_bad;
  logic                  take;
  logic                  restart;
  logic                  complete;
  logic [WW-1:0]         widx_next;
  logic [CW-1:0]         cnt_base;

  logic [MXPADS-1:0]     vpfs_m;
  logic [MXPADS*3-1:0]   cnts_m;
  logic [MXPADS-1:0]     hits_m;
  logic [3:0]            n_m;
  logic                  bad_m;

  // Decode the current word on top of the working maps; a frame_start word
  // always begins from empty maps, which also discards an aborted frame.
  always_comb begin
    word_valid = ({1'b0, adr} < PADS12);
    word_bad   = !word_valid && (adr != NULL_ADR);
    take       = ready_q && ((state_q == ACCUM) || frame_start);
    restart    = take && frame_start;
    widx_next  = restart ? WW'(1) : widx_q + WW'(1);
    complete   = take && (widx_next == '0);
    cnt_base   = CW'(adr) * CW'(3);

    vpfs_m = restart ? '0   : work_vpfs_q;
    cnts_m = restart ? '0   : work_cnts_q;
    hits_m = restart ? '0   : work_hits_q;
    n_m    = restart ? 4'd0 : work_n_q;
    bad_m  = (restart ? 1'b0 : work_bad_q) || word_bad;

    if (word_valid) begin
      vpfs_m[adr]            = 1'b1;
      cnts_m[cnt_base +: 3]  = cnt;
      n_m                    = n_m + 4'd1;
    end

    // Extent adr..adr+cnt, clipped at the last pad without wrapping.
    for (int k = 0; k < 8; k++) begin
      if (word_valid && (3'(k) <= cnt) && (({1'b0, adr} + 12'(k)) < PADS12)) begin
        hits_m[adr + AW'(k)] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    work_vpfs_d   = work_vpfs_q;
    work_cnts_d   = work_cnts_q;
    work_hits_d   = work_hits_q;
    work_n_d      = work_n_q;
    work_bad_d    = work_bad_q;
    vpfs_d        = vpfs_q;
    cnts_d        = cnts_q;
    hits_d        = hits_q;
    n_d           = n_q;
    bad_d         = bad_q;
    frame_valid_d = 1'b0;
    sync_err_d    = sync_err_q;

    if (take) begin
      if (frame_start && (state_q == ACCUM)) begin
        sync_err_d = 1'b1;
      end
      if (complete) begin
        vpfs_d        = vpfs_m;
        cnts_d        = cnts_m;
        hits_d        = hits_m;
        n_d           = n_m;
        bad_d         = bad_m;
        frame_valid_d = 1'b1;
        work_vpfs_d   = '0;
        work_cnts_d   = '0;
        work_hits_d   = '0;
        work_n_d      = 4'd0;
        work_bad_d    = 1'b0;
        state_d       = IDLE;
        widx_d        = '0;
      end else begin
        work_vpfs_d = vpfs_m;
        work_cnts_d = cnts_m;
        work_hits_d = hits_m;
        work_n_d    = n_m;
        work_bad_d  = bad_m;
        state_d     = ACCUM;
        widx_d      = widx_next;
      end
    end
  end

  // ready_q holds the FSM off for the first edge after reset release.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q       <= IDLE;
      widx_q        <= '0;
      ready_q       <= 1'b0;
      work_vpfs_q   <= '0;
      work_cnts_q   <= '0;
      work_hits_q   <= '0;
      work_n_q      <= 4'd0;
      work_bad_q    <= 1'b0;
      vpfs_q        <= '0;
      cnts_q        <= '0;
      hits_q        <= '0;
      n_q           <= 4'd0;
      bad_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      ready_q       <= 1'b1;
      work_vpfs_q   <= work_vpfs_d;
      work_cnts_q   <= work_cnts_d;
      work_hits_q   <= work_hits_d;
      work_n_q      <= work_n_d;
      work_bad_q    <= work_bad_d;
      vpfs_q        <= vpfs_d;
      cnts_q        <= cnts_d;
      hits_q        <= hits_d;
      n_q           <= n_d;
      bad_q         <= bad_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign vpfs        = vpfs_q;
  assign cnts        = cnts_q;
  assign hits        = hits_q;
  assign n_clusters  = n_q;
  assign bad_adr     = bad_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_cluster_unpacker1536.sv
// Directed bench for cluster_unpacker1536: frames are driven on the falling edge and
// outputs are compared against hand-built expected maps on the same falling edge.
module tb_cluster_unpacker1536;

  localparam int NP = 1536;
  localparam logic [10:0] NUL = 11'h7FE;

  logic            clock;
  logic            global_reset;
  logic            frame_start;
  logic [10:0]     adr;
  logic [2:0]      cnt;
  logic [NP-1:0]   vpfs;
  logic [NP*3-1:0] cnts;
  logic [NP-1:0]   hits;
  logic [3:0]      n_clusters;
  logic            bad_adr;
  logic            frame_valid;
  logic            sync_err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [NP-1:0]   exp_vpfs;
  logic [NP*3-1:0] exp_cnts;
  logic [NP-1:0]   exp_hits;

  cluster_unpacker1536 dut (
    .clock        (clock),
    .global_reset (global_reset),
    .frame_start  (frame_start),
    .adr          (adr),
    .cnt          (cnt),
    .vpfs         (vpfs),
    .cnts         (cnts),
    .hits         (hits),
    .n_clusters   (n_clusters),
    .bad_adr      (bad_adr),
    .frame_valid  (frame_valid),
    .sync_err     (sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one word on the falling edge; the DUT samples it on the next rising edge.
  task automatic applyStimulus(input logic fs, input logic [10:0] a, input logic [2:0] c);
    @(negedge clock);
    frame_start = fs;
    adr         = a;
    cnt         = c;
  endtask

  // Idle words, tallying any frame_valid seen while they are driven.
  task automatic idleCount(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, NUL, 3'd0);
      pulses += int'(frame_valid);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkWide(input string tag, input logic [NP*3-1:0] obs, input logic [NP*3-1:0] expv);
    int first;
    first = -1;
    for (int i = NP*3-1; i >= 0; i--) begin
      if (obs[i] !== expv[i]) first = i;
    end
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d bits set, expected %0d bits set, first differing bit %0d",
             tag, $countones(obs), $countones(expv), first);
    end
  endtask

  task automatic clearExp;
    exp_vpfs = '0;
    exp_cnts = '0;
    exp_hits = '0;
  endtask

  task automatic checkMaps(input string tag, input int n, input logic bad);
    checkWide({tag, ".vpfs"}, (NP*3)'(vpfs), (NP*3)'(exp_vpfs));
    checkWide({tag, ".cnts"}, cnts, exp_cnts);
    checkWide({tag, ".hits"}, (NP*3)'(hits), (NP*3)'(exp_hits));
    checkOutput({tag, ".n_clusters"}, 32'(n_clusters), 32'(n));
    checkOutput({tag, ".bad_adr"}, 32'(bad_adr), 32'(bad));
  endtask

  initial begin
    global_reset = 1'b1;
    frame_start  = 1'b0;
    adr          = NUL;
    cnt          = 3'd0;

    // Reset state
    repeat (3) @(negedge clock);
    clearExp();
    checkMaps("reset", 0, 1'b0);
    checkOutput("reset.frame_valid", 32'(frame_valid), 0);
    checkOutput("reset.sync_err", 32'(sync_err), 0);
    global_reset = 1'b0;
    idleCount(3);

    // Single frame, single cluster
    pulses = 0;
    applyStimulus(1'b1, 11'd5, 3'd2);
    pulses += int'(frame_valid);
    idleCount(7);
    checkOutput("t1.no_early_pulse", 32'(pulses), 0);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t1.frame_valid", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[5]         = 1'b1;
    exp_cnts[17:15]     = 3'd2;
    exp_hits[7:5]       = 3'b111;
    checkMaps("t1", 1, 1'b0);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t1.pulse_width", 32'(frame_valid), 0);
    checkWide("t1.hold_hits", (NP*3)'(hits), (NP*3)'(exp_hits));

    // Clip at the top pad and bad address
    applyStimulus(1'b1, 11'd1534, 3'd7);
    applyStimulus(1'b0, 11'd1600, 3'd0);
    applyStimulus(1'b0, NUL, 3'd0);
    idleCount(5);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t2.frame_valid", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[1534]            = 1'b1;
    exp_cnts[1534*3 +: 3]     = 3'd7;
    exp_hits[1534]            = 1'b1;
    exp_hits[1535]            = 1'b1;
    checkMaps("t2", 1, 1'b1);

    // Duplicate start pad and overlapping extents
    applyStimulus(1'b1, 11'd10, 3'd1);
    applyStimulus(1'b0, 11'd10, 3'd4);
    applyStimulus(1'b0, 11'd12, 3'd0);
    idleCount(5);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t3.frame_valid", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[10]        = 1'b1;
    exp_vpfs[12]        = 1'b1;
    exp_cnts[32:30]     = 3'd4;
    exp_hits[14:10]     = 5'b11111;
    checkMaps("t3", 3, 1'b0);

    // Back-to-back frames with no gap
    applyStimulus(1'b1, 11'd0, 3'd0);
    idleCount(7);
    applyStimulus(1'b1, 11'd100, 3'd0);
    checkOutput("t4.pulse_a", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[0] = 1'b1;
    checkWide("t4.vpfs_a", (NP*3)'(vpfs), (NP*3)'(exp_vpfs));
    pulses = 0;
    idleCount(7);
    checkOutput("t4.gap_no_pulse", 32'(pulses), 0);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t4.pulse_b", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[100] = 1'b1;
    exp_hits[100] = 1'b1;
    checkMaps("t4.b", 1, 1'b0);

    // Mid-frame restart at widx=3
    applyStimulus(1'b1, 11'd20, 3'd0);
    applyStimulus(1'b0, 11'd21, 3'd0);
    applyStimulus(1'b0, 11'd22, 3'd0);
    checkOutput("t5.sync_before", 32'(sync_err), 0);
    pulses = 0;
    applyStimulus(1'b1, 11'd30, 3'd1);
    idleCount(7);
    checkOutput("t5.no_aborted_pulse", 32'(pulses), 0);
    checkOutput("t5.sync_err", 32'(sync_err), 1);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t5.frame_valid", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[30]        = 1'b1;
    exp_cnts[92:90]     = 3'd1;
    exp_hits[31:30]     = 2'b11;
    checkMaps("t5", 1, 1'b0);
    idleCount(3);
    checkOutput("t5.sync_sticky", 32'(sync_err), 1);

    // Reset asserted mid-frame at widx=5
    applyStimulus(1'b1, 11'd40, 3'd0);
    applyStimulus(1'b0, 11'd41, 3'd0);
    applyStimulus(1'b0, 11'd42, 3'd0);
    applyStimulus(1'b0, 11'd43, 3'd0);
    applyStimulus(1'b0, 11'd44, 3'd0);
    @(posedge clock);
    #2;
    global_reset = 1'b1;
    #1;
    clearExp();
    checkMaps("t6.async", 0, 1'b0);
    checkOutput("t6.sync_cleared", 32'(sync_err), 0);
    @(negedge clock);
    global_reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 11'(50 + i), 3'd1);
      pulses += int'(frame_valid);
    end
    idleCount(2);
    checkOutput("t6.no_pulse_without_start", 32'(pulses), 0);
    checkWide("t6.vpfs_still_zero", (NP*3)'(vpfs), (NP*3)'(exp_vpfs));

    // Recovery frame after reset
    applyStimulus(1'b1, 11'd200, 3'd3);
    idleCount(7);
    applyStimulus(1'b0, NUL, 3'd0);
    checkOutput("t7.frame_valid", 32'(frame_valid), 1);
    clearExp();
    exp_vpfs[200]         = 1'b1;
    exp_cnts[200*3 +: 3]  = 3'd3;
    exp_hits[203:200]     = 4'b1111;
    checkMaps("t7", 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_unpacker1536.md
# cluster_unpacker1536

Receive-side decoder for the 1536-pad priority-encoded cluster stream. It accepts one {adr, cnt} cluster word per clock in frames of MXCLUSTERS words and rebuilds per-frame pad maps: cluster-start flags with their 3-bit counts, and an expanded hit map. It sits downstream of the cluster packer, in the trigger-side receiver and in the test bench as the golden inverse. One frame's maps are presented at a time, double-buffered, so the previous frame stays stable while the next one accumulates.

## Interface
Parameters:
- MXPADS, 1536, number of pads; adr values ≥ MXPADS are not real pads.
- MXCLUSTERS, 8, cluster words per frame (power of two).

Ports:
- clock  in  1  single system clock; everything is on its rising edge.
- global_reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  marks the word on adr/cnt this cycle as word 0 of a frame.
- adr  in  11  cluster start pad; 11'h7FE means no cluster.
- cnt  in  3  cluster count at the start pad; extent is cnt+1 pads.
- vpfs  out  MXPADS  cluster-start flags of the last completed frame.
- cnts  out  MXPADS*3  per-pad count; pad i occupies bits [3i+2:3i].
- hits  out  MXPADS  expanded hit map of the last completed frame.
- n_clusters  out  4  number of valid words in the last completed frame.
- bad_adr  out  1  the last completed frame had ≥1 word with adr ≥ MXPADS other than 7FE.
- frame_valid  out  1  one-cycle pulse when the outputs above are updated.
- sync_err  out  1  sticky flag: a frame_start arrived mid-frame; cleared only by reset.

## Operation
State machine:
- States are IDLE and ACCUM. Word index widx is log2(MXCLUSTERS) bits.
- IDLE: the word is ignored unless frame_start=1. If frame_start=1, the word is taken as word 0, widx becomes 1, and the state goes to ACCUM.
- ACCUM: every cycle takes one word at widx, with or without frame_start.
  - On word MXCLUSTERS-1 (widx wraps to 0), the frame completes.
  - After completion, the next state is ACCUM only if frame_start=1 on the following cycle; otherwise IDLE. Back-to-back frames therefore have no gap.
- frame_start=1 in ACCUM with widx≠0:
  - Set sync_err.
  - Discard the working accumulation, with no frame_valid.
  - Restart with this word as word 0 (widx=1).

Word decode:
- A word is valid iff adr < MXPADS.
- adr = 11'h7FE: ignored, not counted.
- Any other adr ≥ MXPADS: ignored, not counted, and sets working bad_adr.
- Valid word effects:
  - vpfs[adr] |= 1.
  - cnts[adr] = cnt; a duplicate adr in the same frame gets the last-written cnt.
  - hits[p] |= 1 for adr ≤ p ≤ min(adr+cnt, MXPADS-1). Clip at 1535 with no wrap; compute adr+cnt at 12 bits.
  - Working n_clusters += 1. Maximum is MXCLUSTERS, so 4 bits never saturate at default.

Frame completion:
- The outputs load working state merged with the decode of the final word.
- The working state clears to zero in the same edge.
- frame_valid pulses.

## Timing
- Reset values: vpfs=0, cnts=0, hits=0, n_clusters=0, bad_adr=0, frame_valid=0, sync_err=0, state=IDLE, widx=0, working maps 0.
- Latency: the final word sampled at edge N gives outputs updated and frame_valid=1 during the cycle after edge N. Outputs then hold until the next completion.
- The output registers are the only outputs; there are no combinational paths from inputs to outputs.
- Reset asserted mid-frame: the partial frame is lost immediately, all outputs go to reset values, and no frame_valid is produced.
- Reset deassertion is synchronised internally before it releases the FSM. The first frame_start is honoured from the 2nd edge after deassertion.

## Test plan
- **Single frame, single cluster:** frame_start with adr=5, cnt=2, then 7 words of 7FE. Required response:
  - frame_valid exactly one cycle after word 7.
  - vpfs has only bit 5 set.
  - cnts[17:15]=2.
  - hits bits 5..7 set.
  - n_clusters=1, bad_adr=0.
- **Clip and bad address:** words adr=1534 cnt=7, adr=1600, adr=7FE, … Required response:
  - hits has only bits 1534 and 1535 set.
  - n_clusters=1, bad_adr=1.
- **Duplicate and overlap:** adr=10 cnt=1, then adr=10 cnt=4, then adr=12 cnt=0. Required response:
  - cnts pad 10 = 4.
  - vpfs bits 10 and 12 set.
  - hits bits 10..14 set.
  - n_clusters=3.
- **Back-to-back frames:** frame A (adr=0), then frame_start the very next cycle with frame B (adr=100). Required response:
  - Two frame_valid pulses 8 cycles apart.
  - The second output shows only pad 100; A has been cleared.
- **Mid-frame restart:** frame_start at widx=3. Required response:
  - sync_err=1 and stays at 1.
  - No frame_valid for the aborted frame.
  - The new frame completes 8 words after the restart.
- **Reset mid-frame:** global_reset asserted at widx=5 after a prior completed frame. Required response:
  - All outputs return to 0 asynchronously.
  - After release, words without frame_start produce no frame_valid.
